// File: rtl/mem_arbiter.sv
// Arbiter/sequencer between instruction fetch and load/store for the single byte-serial
// memory controller: LS priority, bounded IF starvation, fetch flush, one idle cycle per txn.
module mem_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              if_flush_i,
  output logic              if_done_o,
  output logic [DATA_W-1:0] if_inst_o,
  input  logic              ls_req_i,
  input  logic              ls_we_i,
  input  logic [ADDR_W-1:0] ls_addr_i,
  input  logic [DATA_W-1:0] ls_wdata_i,
  input  logic [2:0]        ls_len_i,
  output logic              ls_done_o,
  output logic [DATA_W-1:0] ls_rdata_o,
  output logic              mc_if_req_o,
  output logic              mc_read_req_o,
  output logic              mc_write_req_o,
  output logic [ADDR_W-1:0] mc_inst_addr_o,
  output logic [ADDR_W-1:0] mc_mem_addr_o,
  output logic [DATA_W-1:0] mc_wdata_o,
  output logic [2:0]        mc_store_len_o,
  input  logic              mc_inst_done_i,
  input  logic              mc_mem_done_i,
  input  logic [DATA_W-1:0] mc_inst_i,
  input  logic [DATA_W-1:0] mc_mem_val_i,
  output logic [1:0]        busy_o
);

  localparam int unsigned CntW = (STARVE_LIM > 0) ? $clog2(STARVE_LIM + 1) : 1;
  localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_LIM);

  typedef enum logic [2:0] {StIdle, StGap, StIfRun, StIfDrop, StLsRun} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   starve_q, starve_d;
  logic              if_req_q, if_req_d;
  logic              rd_req_q, rd_req_d;
  logic              wr_req_q, wr_req_d;
  logic [ADDR_W-1:0] inst_addr_q, inst_addr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [2:0]        len_q, len_d;
  logic              if_done_q, if_done_d;
  logic [DATA_W-1:0] if_inst_q, if_inst_d;
  logic              ls_done_q, ls_done_d;
  logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
  logic              if_elig;

  // A flushed fetch is not eligible for grant in the same cycle.
  assign if_elig = if_req_i && !if_flush_i;

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    if_req_d    = if_req_q;
    rd_req_d    = rd_req_q;
    wr_req_d    = wr_req_q;
    inst_addr_d = inst_addr_q;
    mem_addr_d  = mem_addr_q;
    wdata_d     = wdata_q;
    len_d       = len_q;
    if_done_d   = 1'b0;
    if_inst_d   = if_inst_q;
    ls_done_d   = 1'b0;
    ls_rdata_d  = ls_rdata_q;
    if (rdy_in) begin
      case (state_q)
        StIdle: begin
          if (ls_req_i && !(if_elig && starve_q == StarveMax)) begin
            mem_addr_d = ls_addr_i;
            wdata_d    = ls_wdata_i;
            len_d      = ls_len_i;
            wr_req_d   = ls_we_i;
            rd_req_d   = !ls_we_i;
            state_d    = StLsRun;
            // LS can only win over a waiting IF while the counter is below its limit.
            if (if_elig) starve_d = starve_q + CntW'(1);
          end else if (if_elig) begin
            inst_addr_d = if_addr_i;
            if_req_d    = 1'b1;
            starve_d    = '0;
            state_d     = StIfRun;
          end
        end
        StIfRun: begin
          if (if_flush_i) begin
            if (mc_inst_done_i) begin
              if_req_d = 1'b0;
              state_d  = StGap;
            end else begin
              state_d = StIfDrop;
            end
          end else if (mc_inst_done_i) begin
            if_req_d  = 1'b0;
            if_done_d = 1'b1;
            if_inst_d = mc_inst_i;
            state_d   = StGap;
          end
        end
        StIfDrop: begin
          // Controller must finish the byte sequence; the result is discarded.
          if (mc_inst_done_i) begin
            if_req_d = 1'b0;
            state_d  = StGap;
          end
        end
        StLsRun: begin
          if (mc_mem_done_i) begin
            rd_req_d   = 1'b0;
            wr_req_d   = 1'b0;
            ls_done_d  = 1'b1;
            ls_rdata_d = wr_req_q ? '0 : mc_mem_val_i;
            state_d    = StGap;
          end
        end
        StGap:   state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= StIdle;
      starve_q    <= '0;
      if_req_q    <= 1'b0;
      rd_req_q    <= 1'b0;
      wr_req_q    <= 1'b0;
      inst_addr_q <= '0;
      mem_addr_q  <= '0;
      wdata_q     <= '0;
      len_q       <= '0;
      if_done_q   <= 1'b0;
      if_inst_q   <= '0;
      ls_done_q   <= 1'b0;
      ls_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      if_req_q    <= if_req_d;
      rd_req_q    <= rd_req_d;
      wr_req_q    <= wr_req_d;
      inst_addr_q <= inst_addr_d;
      mem_addr_q  <= mem_addr_d;
      wdata_q     <= wdata_d;
      len_q       <= len_d;
      if_done_q   <= if_done_d;
      if_inst_q   <= if_inst_d;
      ls_done_q   <= ls_done_d;
      ls_rdata_q  <= ls_rdata_d;
    end
  end

  // Done pulses are suppressed while the pipeline is stalled.
  assign if_done_o      = if_done_q && rdy_in;
  assign ls_done_o      = ls_done_q && rdy_in;
  assign if_inst_o      = if_inst_q;
  assign ls_rdata_o     = ls_rdata_q;
  assign mc_if_req_o    = if_req_q;
  assign mc_read_req_o  = rd_req_q;
  assign mc_write_req_o = wr_req_q;
  assign mc_inst_addr_o = inst_addr_q;
  assign mc_mem_addr_o  = mem_addr_q;
  assign mc_wdata_o     = wdata_q;
  assign mc_store_len_o = len_q;
  assign busy_o         = {(state_q == StIfRun) || (state_q == StIfDrop), state_q == StLsRun};

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by randomized traffic checked against a
// transaction-level arbitration model with a behavioural controller.
module tb_mem_arbiter;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned LIM = 4;

  logic          clk_in = 1'b0;
  logic          rst_in, rdy_in;
  logic          if_req_i, if_flush_i, if_done_o;
  logic [AW-1:0] if_addr_i;
  logic [DW-1:0] if_inst_o;
  logic          ls_req_i, ls_we_i, ls_done_o;
  logic [AW-1:0] ls_addr_i;
  logic [DW-1:0] ls_wdata_i, ls_rdata_o;
  logic [2:0]    ls_len_i, mc_store_len_o;
  logic          mc_if_req_o, mc_read_req_o, mc_write_req_o;
  logic [AW-1:0] mc_inst_addr_o, mc_mem_addr_o;
  logic [DW-1:0] mc_wdata_o, mc_inst_i, mc_mem_val_i;
  logic          mc_inst_done_i, mc_mem_done_i;
  logic [1:0]    busy_o;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIM(LIM)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
    .if_done_o(if_done_o), .if_inst_o(if_inst_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_addr_i(ls_addr_i), .ls_wdata_i(ls_wdata_i),
    .ls_len_i(ls_len_i), .ls_done_o(ls_done_o), .ls_rdata_o(ls_rdata_o),
    .mc_if_req_o(mc_if_req_o), .mc_read_req_o(mc_read_req_o), .mc_write_req_o(mc_write_req_o),
    .mc_inst_addr_o(mc_inst_addr_o), .mc_mem_addr_o(mc_mem_addr_o), .mc_wdata_o(mc_wdata_o),
    .mc_store_len_o(mc_store_len_o), .mc_inst_done_i(mc_inst_done_i),
    .mc_mem_done_i(mc_mem_done_i), .mc_inst_i(mc_inst_i), .mc_mem_val_i(mc_mem_val_i),
    .busy_o(busy_o)
  );

  always #5 clk_in = ~clk_in;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Random-phase model state
  int            kind;      // 0 none, 1 fetch in flight, 2 load/store in flight
  int            starve;
  int            dec_edge;
  int            ctl_wait;
  int            ls_cnt;
  bit            done_drv, seen_if, exp_ifd, exp_lsd, if_el, ls_el;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, ctl_val;
  logic [2:0]    m_len;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    rdy_in = 1'b1; if_req_i = 1'b0; if_addr_i = '0; if_flush_i = 1'b0;
    ls_req_i = 1'b0; ls_we_i = 1'b0; ls_addr_i = '0; ls_wdata_i = '0; ls_len_i = '0;
    mc_inst_done_i = 1'b0; mc_mem_done_i = 1'b0; mc_inst_i = '0; mc_mem_val_i = '0;
  endtask

  task automatic zero_chk(input string tag);
    chk({tag, "_if_req"}, mc_if_req_o, 0);
    chk({tag, "_rd_req"}, mc_read_req_o, 0);
    chk({tag, "_wr_req"}, mc_write_req_o, 0);
    chk({tag, "_iaddr"}, mc_inst_addr_o, 0);
    chk({tag, "_maddr"}, mc_mem_addr_o, 0);
    chk({tag, "_wdata"}, mc_wdata_o, 0);
    chk({tag, "_len"}, mc_store_len_o, 0);
    chk({tag, "_if_done"}, if_done_o, 0);
    chk({tag, "_if_inst"}, if_inst_o, 0);
    chk({tag, "_ls_done"}, ls_done_o, 0);
    chk({tag, "_ls_rdata"}, ls_rdata_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in = 1'b1;
    idle_inputs();
    tick(); tick();
    zero_chk("reset");
    rst_in = 1'b0;
    tick();
    zero_chk("idle");

    // Fetch only
    if_req_i = 1'b1; if_addr_i = 32'h100;
    tick();
    chk("fetch_req", mc_if_req_o, 1);
    chk("fetch_addr", mc_inst_addr_o, 32'h100);
    chk("fetch_busy", busy_o, 2'b10);
    tick();
    chk("fetch_hold", mc_if_req_o, 1);
    mc_inst_done_i = 1'b1; mc_inst_i = 32'h00A00093;
    tick();
    mc_inst_done_i = 1'b0; if_req_i = 1'b0;
    chk("fetch_done", if_done_o, 1);
    chk("fetch_inst", if_inst_o, 32'h00A00093);
    chk("fetch_gap_req", mc_if_req_o, 0);
    chk("fetch_gap_busy", busy_o, 0);
    tick();
    chk("fetch_done_pulse", if_done_o, 0);
    chk("fetch_idle_req", mc_if_req_o, 0);

    // Simultaneous requests: LS first, IF after the gap
    if_req_i = 1'b1; if_addr_i = 32'h200;
    ls_req_i = 1'b1; ls_we_i = 1'b0; ls_addr_i = 32'h1000;
    tick();
    chk("sim_rd_req", mc_read_req_o, 1);
    chk("sim_if_req_low", mc_if_req_o, 0);
    chk("sim_maddr", mc_mem_addr_o, 32'h1000);
    mc_mem_done_i = 1'b1; mc_mem_val_i = 32'h55AA_1234;
    tick();
    mc_mem_done_i = 1'b0; ls_req_i = 1'b0;
    chk("sim_ls_done", ls_done_o, 1);
    chk("sim_ls_rdata", ls_rdata_o, 32'h55AA_1234);
    chk("sim_gap", {mc_if_req_o, mc_read_req_o}, 0);
    tick();
    chk("sim_idle", mc_if_req_o, 0);
    tick();
    chk("sim_if_req", mc_if_req_o, 1);
    chk("sim_iaddr", mc_inst_addr_o, 32'h200);
    mc_inst_done_i = 1'b1; mc_inst_i = 32'h1;
    tick();
    mc_inst_done_i = 1'b0; if_req_i = 1'b0;
    chk("sim_if_done", if_done_o, 1);
    tick();

    // Starvation: continuous LS, IF held; two rounds
    if_req_i = 1'b1; if_addr_i = 32'h600;
    ls_req_i = 1'b1; ls_we_i = 1'b0; ls_addr_i = 32'h700;
    for (int r = 0; r < 2; r++) begin
      ls_cnt = 0; seen_if = 1'b0;
      for (int i = 0; i < 100 && !seen_if; i++) begin
        mc_mem_done_i = mc_read_req_o; mc_mem_val_i = i;
        tick();
        ls_cnt += int'(mc_read_req_o);
        seen_if = mc_if_req_o;
      end
      chk("starve_ls_grants", ls_cnt, LIM);
      chk("starve_if_grant", seen_if, 1);
      chk("starve_iaddr", mc_inst_addr_o, 32'h600 + 4 * r);
      mc_mem_done_i = 1'b0; mc_inst_done_i = 1'b1; mc_inst_i = 32'hABC0 + r;
      tick();
      mc_inst_done_i = 1'b0; if_addr_i = 32'h604;
      chk("starve_if_done", if_done_o, 1);
      chk("starve_if_inst", if_inst_o, 32'hABC0 + r);
    end
    if_req_i = 1'b0; ls_req_i = 1'b0;
    tick(); tick();

    // Flush during IF_RUN
    if_req_i = 1'b1; if_addr_i = 32'h300;
    tick();
    chk("flush_grant", mc_if_req_o, 1);
    if_flush_i = 1'b1; if_req_i = 1'b0;
    tick();
    chk("flush_hold_req", mc_if_req_o, 1);
    chk("flush_hold_addr", mc_inst_addr_o, 32'h300);
    if_flush_i = 1'b0; if_req_i = 1'b1; if_addr_i = 32'h400;
    tick(); tick();
    chk("flush_drop_req", mc_if_req_o, 1);
    chk("flush_drop_addr", mc_inst_addr_o, 32'h300);
    chk("flush_drop_busy", busy_o, 2'b10);
    mc_inst_done_i = 1'b1; mc_inst_i = 32'hBAD;
    tick();
    mc_inst_done_i = 1'b0;
    chk("flush_no_done", if_done_o, 0);
    chk("flush_gap", mc_if_req_o, 0);
    tick();
    chk("flush_idle", mc_if_req_o, 0);
    tick();
    chk("flush_new_req", mc_if_req_o, 1);
    chk("flush_new_addr", mc_inst_addr_o, 32'h400);
    mc_inst_done_i = 1'b1; mc_inst_i = 32'h13;
    tick();
    mc_inst_done_i = 1'b0; if_req_i = 1'b0;
    chk("flush_new_done", if_done_o, 1);
    chk("flush_new_inst", if_inst_o, 32'h13);
    tick();

    // Flush and done in the same cycle
    if_req_i = 1'b1; if_addr_i = 32'h500;
    tick();
    if_flush_i = 1'b1; if_req_i = 1'b0; mc_inst_done_i = 1'b1; mc_inst_i = 32'h77;
    tick();
    if_flush_i = 1'b0; mc_inst_done_i = 1'b0;
    chk("fd_no_done", if_done_o, 0);
    chk("fd_req_low", mc_if_req_o, 0);
    chk("fd_busy", busy_o, 0);
    tick();

    // Store, with inputs changed after grant and a mismatched done
    ls_req_i = 1'b1; ls_we_i = 1'b1; ls_addr_i = 32'h2000;
    ls_wdata_i = 32'hDEADBEEF; ls_len_i = 3'd3;
    tick();
    ls_we_i = 1'b0; ls_addr_i = 32'hFFFF_FFF0; ls_wdata_i = '0; ls_len_i = 3'd5;
    mc_inst_done_i = 1'b1; mc_inst_i = 32'h99;
    for (int i = 0; i < 3; i++) begin
      chk("st_wr_req", mc_write_req_o, 1);
      chk("st_rd_req", mc_read_req_o, 0);
      chk("st_addr", mc_mem_addr_o, 32'h2000);
      chk("st_wdata", mc_wdata_o, 32'hDEADBEEF);
      chk("st_len", mc_store_len_o, 3);
      chk("st_no_if_done", if_done_o, 0);
      tick();
      mc_inst_done_i = 1'b0;
    end
    mc_mem_done_i = 1'b1; mc_mem_val_i = 32'h12345678;
    tick();
    mc_mem_done_i = 1'b0; ls_req_i = 1'b0;
    chk("st_done", ls_done_o, 1);
    chk("st_rdata", ls_rdata_o, 0);
    chk("st_gap", mc_write_req_o, 0);
    tick();

    // rdy low: no grant, freeze, lost done
    rdy_in = 1'b0; ls_req_i = 1'b1; ls_we_i = 1'b0; ls_addr_i = 32'h1234;
    tick();
    chk("rdy_no_grant", mc_read_req_o, 0);
    rdy_in = 1'b1;
    tick();
    chk("rdy_grant", mc_read_req_o, 1);
    rdy_in = 1'b0; mc_mem_done_i = 1'b1; mc_mem_val_i = 32'h42;
    tick();
    chk("rdy_frz_done", ls_done_o, 0);
    chk("rdy_frz_req", mc_read_req_o, 1);
    mc_mem_done_i = 1'b0; rdy_in = 1'b1;
    tick();
    chk("rdy_lost_done", ls_done_o, 0);
    chk("rdy_still_req", mc_read_req_o, 1);
    mc_mem_done_i = 1'b1;
    tick();
    mc_mem_done_i = 1'b0; ls_req_i = 1'b0;
    chk("rdy_done", ls_done_o, 1);
    chk("rdy_rdata", ls_rdata_o, 32'h42);
    tick();

    // Asynchronous reset in LS_RUN
    ls_req_i = 1'b1; ls_addr_i = 32'h3000; ls_wdata_i = 32'h5;
    tick();
    chk("rst_pre_req", mc_read_req_o, 1);
    #2 rst_in = 1'b1;
    #1;
    zero_chk("rst_mid");
    ls_req_i = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b0;
    ls_req_i = 1'b1; ls_addr_i = 32'h3004;
    tick();
    chk("rst_regrant", mc_read_req_o, 1);
    chk("rst_regrant_addr", mc_mem_addr_o, 32'h3004);
    mc_mem_done_i = 1'b1; mc_mem_val_i = 32'h66;
    tick();
    mc_mem_done_i = 1'b0; ls_req_i = 1'b0;
    chk("rst_regrant_done", ls_done_o, 1);
    idle_inputs();
    tick(); tick(); tick();

    // Randomized traffic against the transaction-level model
    kind = 0; starve = 0; done_drv = 1'b0; ctl_wait = 0; m_we = 1'b0;
    m_addr = '0; m_wdata = '0; m_len = '0; ctl_val = '0;
    dec_edge = cyc + 1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      exp_ifd = 1'b0; exp_lsd = 1'b0;
      if (done_drv) begin
        if (kind == 1) begin
          exp_ifd = 1'b1;
          chk("rnd_if_inst", if_inst_o, ctl_val);
          if_req_i = 1'b0;
        end else begin
          exp_lsd = 1'b1;
          chk("rnd_ls_rdata", ls_rdata_o, m_we ? 32'h0 : ctl_val);
          ls_req_i = 1'b0;
        end
        kind = 0; done_drv = 1'b0; dec_edge = cyc + 2;
      end else if (cyc == dec_edge) begin
        if_el = if_req_i; ls_el = ls_req_i;
        if (ls_el && !(if_el && starve == LIM)) begin
          kind = 2; m_we = ls_we_i; m_addr = ls_addr_i; m_wdata = ls_wdata_i; m_len = ls_len_i;
          if (if_el) starve = (starve < LIM) ? starve + 1 : LIM;
        end else if (if_el) begin
          kind = 1; m_addr = if_addr_i; starve = 0;
        end else begin
          dec_edge = cyc + 1;
        end
        ctl_wait = $urandom_range(0, 3);
      end
      chk("rnd_onehot",
          int'(mc_if_req_o) + int'(mc_read_req_o) + int'(mc_write_req_o) <= 1, 1);
      chk("rnd_if_req", mc_if_req_o, kind == 1);
      chk("rnd_rd_req", mc_read_req_o, kind == 2 && !m_we);
      chk("rnd_wr_req", mc_write_req_o, kind == 2 && m_we);
      chk("rnd_if_done", if_done_o, exp_ifd);
      chk("rnd_ls_done", ls_done_o, exp_lsd);
      chk("rnd_busy", busy_o, {kind == 1, kind == 2});
      if (kind == 1) chk("rnd_iaddr", mc_inst_addr_o, m_addr);
      if (kind == 2) begin
        chk("rnd_maddr", mc_mem_addr_o, m_addr);
        chk("rnd_wdata", mc_wdata_o, m_wdata);
        chk("rnd_len", mc_store_len_o, m_len);
      end
      // Stimulus for the next edge
      mc_inst_done_i = 1'b0; mc_mem_done_i = 1'b0;
      mc_inst_i = $urandom; mc_mem_val_i = $urandom;
      if (kind == 1) begin
        if_addr_i = $urandom;
        if ($urandom_range(0, 7) == 0) mc_mem_done_i = 1'b1;
      end else if (kind == 2) begin
        ls_we_i = 1'($urandom); ls_addr_i = $urandom; ls_wdata_i = $urandom;
        ls_len_i = 3'($urandom);
        if ($urandom_range(0, 7) == 0) mc_inst_done_i = 1'b1;
      end
      if (kind != 0 && !done_drv) begin
        if (ctl_wait == 0) begin
          ctl_val = $urandom; done_drv = 1'b1;
          if (kind == 1) begin
            mc_inst_done_i = 1'b1; mc_inst_i = ctl_val;
          end else begin
            mc_mem_done_i = 1'b1; mc_mem_val_i = ctl_val;
          end
        end else begin
          ctl_wait--;
        end
      end
      if (!if_req_i && $urandom_range(0, 2) == 0) begin
        if_req_i = 1'b1; if_addr_i = $urandom & 32'hFFFF_FFFC;
      end
      if (!ls_req_i && $urandom_range(0, 2) == 0) begin
        ls_req_i = 1'b1; ls_we_i = 1'($urandom); ls_addr_i = $urandom;
        ls_wdata_i = $urandom; ls_len_i = 3'($urandom);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates and sequences the single byte-serial memory controller between the instruction-fetch unit (IF) and the load/store unit (LS). It accepts one level-held request per requester, grants one at a time, drives exactly one of the controller's `if_req`/`read_req`/`write_req` inputs with stable address and data, and returns a one-cycle done pulse with result data to the granted requester. It sits between IF/MEM and `mem_ctrl`. It guarantees that the controller always sees one idle cycle between transactions, and it provides LS priority with bounded IF starvation plus IF flush handling.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `STARVE_LIM`, default 4: number of consecutive LS grants allowed while IF waits.

Ports:
- `clk_in`  in  1  clock; all state updates on the rising edge.
- `rst_in`  in  1  asynchronous, active-high reset.
- `rdy_in`  in  1  global ready; low freezes the arbiter.
- `if_req_i`  in  1  fetch request; held high until `if_done_o` is seen or a flush occurs.
- `if_addr_i`  in  ADDR_W  fetch address.
- `if_flush_i`  in  1  cancels the pending or in-flight fetch.
- `if_done_o`  out  1  one-cycle pulse indicating fetch complete.
- `if_inst_o`  out  DATA_W  fetched word; valid while `if_done_o` is high.
- `ls_req_i`  in  1  load/store request; held high until `ls_done_o`.
- `ls_we_i`  in  1  1 = store, 0 = load.
- `ls_addr_i`  in  ADDR_W  load/store address.
- `ls_wdata_i`  in  DATA_W  store data.
- `ls_len_i`  in  3  store length code; passed to the controller's `store_len`.
- `ls_done_o`  out  1  one-cycle completion pulse.
- `ls_rdata_o`  out  DATA_W  load data; valid while `ls_done_o` is high.
- `mc_if_req_o`, `mc_read_req_o`, `mc_write_req_o`  out  1 each  controller requests; at most one is high at any time.
- `mc_inst_addr_o`, `mc_mem_addr_o`  out  ADDR_W  latched transaction address.
- `mc_wdata_o`  out  DATA_W  latched store data.
- `mc_store_len_o`  out  3  latched store length.
- `mc_inst_done_i`, `mc_mem_done_i`  in  1  controller completion pulses.
- `mc_inst_i`, `mc_mem_val_i`  in  DATA_W  controller result data.
- `busy_o`  out  2  bit 1 = IF transaction in flight, bit 0 = LS transaction in flight.

## Operation
- FSM states: IDLE, GAP, IF_RUN, IF_DROP, LS_RUN.
- **IDLE.** The arbiter evaluates requests.
  - If `if_flush_i` is high, IF is not eligible this cycle.
  - LS and IF both eligible: LS wins unless `starve_cnt == STARVE_LIM`, in which case IF wins.
  - Granting LS:
    - latch address, data and length;
    - `ls_we_i` selects `mc_write_req_o` (1) or `mc_read_req_o` (0);
    - go to LS_RUN;
    - if an IF request is pending and was not granted, `starve_cnt` increments, saturating at STARVE_LIM.
  - Granting IF: latch the address, assert `mc_if_req_o`, clear `starve_cnt`, go to IF_RUN.
- **IF_RUN.**
  - `if_flush_i` high → go to IF_DROP.
  - `mc_inst_done_i` high with no flush → `if_done_o` = 1 and `if_inst_o` = `mc_inst_i` for one cycle, request dropped, go to GAP.
  - Flush and done in the same cycle: the flush wins. No `if_done_o` is issued, and the FSM goes to GAP.
- **IF_DROP.** `mc_if_req_o` stays high with the same address until `mc_inst_done_i`. The result is discarded, no `if_done_o` is issued, then go to GAP.
- **LS_RUN.** On `mc_mem_done_i`:
  - `ls_done_o` = 1 and `ls_rdata_o` = `mc_mem_val_i` (0 for stores);
  - request dropped;
  - go to GAP.
  - `if_flush_i` has no effect on LS.
- **GAP.** All `mc_*_req_o` are low for exactly one cycle so the controller clears its byte counter, then go to IDLE.
- A done input that does not match the current state is ignored.
- `rdy_in` low: FSM, counter and all outputs hold their values, and done outputs are forced to 0. A pending done pulse from the controller in that cycle is lost, so the controller must also be stalled.
- `busy_o` = {IF_RUN or IF_DROP, LS_RUN}.

## Timing
- Reset values: every output is 0; state = IDLE; `starve_cnt` = 0; latched address and data registers = 0. Reset is asynchronous and takes effect mid-transaction, and all `mc_*_req_o` drop immediately.
- Grant latency: a request sampled in IDLE at edge t drives `mc_*_req_o` high after edge t.
- Completion latency: a controller done sampled at edge d drives the registered `*_done_o` high for the cycle after edge d; the request is low in that same cycle (GAP).
- Minimum spacing between consecutive grants: done cycle + GAP + IDLE.
- `mc_*_addr_o`, `mc_wdata_o` and `mc_store_len_o` are stable for the whole time the request is high.
- Requester inputs are only sampled at the grant.

## Test plan
- Fetch only: `if_req_i`, addr 0x100; controller returns `mc_inst_done_i` with 0x00A00093 → one `if_done_o` pulse with `if_inst_o` = 0x00A00093; `mc_if_req_o` low for exactly one cycle afterwards.
- Simultaneous requests: IF at 0x200 and LS load at 0x1000 in the same IDLE cycle → `mc_read_req_o` first with address 0x1000, then `mc_if_req_o` with 0x200 after GAP.
- Starvation (STARVE_LIM = 4): IF held high, LS re-requests continuously → exactly 4 LS grants, then an IF grant, then `starve_cnt` = 0.
- Flush in IF_RUN, addr 0x300: `mc_if_req_o` stays high until `mc_inst_done_i`, no `if_done_o` is issued, and a new fetch at 0x400 is granted after GAP.
- Store: `ls_we_i` = 1, addr 0x2000, data 0xDEADBEEF, len 3 → `mc_write_req_o` with those values held stable until done; `ls_done_o` pulses with `ls_rdata_o` = 0.
- Reset mid-LS_RUN: `mc_read_req_o` falls asynchronously and all outputs are 0; after release, a fresh request is granted normally.
